// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a 2-entry prefetch buffer, and hands {pc, instr} to decode.
// Define IFETCH_PERF_CNT_EN to add saturating push and stall counters.
module ifetch_ctrl #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [PC_W-1:0] BOOT_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_instr,
`ifdef IFETCH_PERF_CNT_EN
  output logic [15:0]     perf_fetch_cnt,
  output logic [15:0]     perf_stall_cnt,
`endif
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(4 * (MEM_WORDS - 1));

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic [PC_W-1:0]   ent0_pc_q, ent0_pc_d, ent1_pc_q, ent1_pc_d;
  logic [31:0]       ent0_instr_q, ent0_instr_d, ent1_instr_q, ent1_instr_d;
  logic              push, pop;
  logic [1:0]        wr_pos;

  assign pop  = if_valid && if_ready;
  assign push = (state_q == RUN) && !redirect_valid && !stall && ((count_q < 2'd2) || pop);
  // Tail slot after this cycle's pop has shifted entry 1 into the head.
  assign wr_pos = count_q - {1'b0, pop};

  // NOTE: every signal gets a default at the top of the always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    ent0_pc_d    = ent0_pc_q;
    ent0_instr_d = ent0_instr_q;
    ent1_pc_d    = ent1_pc_q;
    ent1_instr_d = ent1_instr_q;

    if (redirect_valid && (state_q != IDLE)) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
      state_d = RUN;
    end else begin
      if (state_q == IDLE && start) begin
        pc_d    = BOOT_ADDR;
        state_d = RUN;
      end
      if (pop) begin
        ent0_pc_d    = ent1_pc_q;
        ent0_instr_d = ent1_instr_q;
      end
      if (push) begin
        if (wr_pos == 2'd0) begin
          ent0_pc_d    = pc_q;
          ent0_instr_d = imem_instr;
        end else begin
          ent1_pc_d    = pc_q;
          ent1_instr_d = imem_instr;
        end
        if (pc_q == LAST_PC) state_d = DONE;
        else                 pc_d    = pc_q + PC_W'(4);
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  // NOTE: buffer entries are reset as well because they drive if_pc/if_instr, which must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      count_q      <= 2'd0;
      ent0_pc_q    <= '0;
      ent0_instr_q <= '0;
      ent1_pc_q    <= '0;
      ent1_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      ent0_pc_q    <= ent0_pc_d;
      ent0_instr_q <= ent0_instr_d;
      ent1_pc_q    <= ent1_pc_d;
      ent1_instr_q <= ent1_instr_d;
    end
  end

  assign imem_pc  = pc_q;
  assign if_valid = (count_q != 2'd0);
  assign if_pc    = ent0_pc_q;
  assign if_instr = ent0_instr_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE) && (count_q == 2'd0);

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        clr_cnt;

  assign clr_cnt = (state_q == IDLE) && start;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (push && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
      if ((state_q == RUN) && (stall || count_q == 2'd2) && stall_cnt_q != 16'hFFFF)
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: basic fetch, backpressure, redirect flush, end of memory, stall and async reset.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stall, redirect_valid, if_ready;
  logic [7:0]  redirect_pc, imem_pc, if_pc;
  logic [31:0] imem_instr, if_instr;
  logic        if_valid, busy, done;
  logic [31:0] mem [64];
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[7:2]];

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
`ifdef IFETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h11 * (i + 1);
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; if_ready = 1'b0;
    #12;
    check("rst_imem_pc", 32'(imem_pc), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", 32'(if_pc), 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    step();

    // Basic fetch
    start = 1'b1;
    step();
    start = 1'b0; if_ready = 1'b1;
    check("start_busy", 32'(busy), 32'h1);
    check("start_imem_pc", 32'(imem_pc), 32'h0);
    check("start_no_valid", 32'(if_valid), 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetch_clr", 32'(perf_fetch_cnt), 32'h0);
    check("perf_stall_clr", 32'(perf_stall_cnt), 32'h0);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      check("basic_valid", 32'(if_valid), 32'h1);
      check("basic_pc", 32'(if_pc), 32'(4 * k));
      check("basic_instr", if_instr, 32'h11 * (k + 1));
    end
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetch4", 32'(perf_fetch_cnt), 32'h4);
    check("perf_stall0", 32'(perf_stall_cnt), 32'h0);
`endif

    // Backpressure: restart, hold if_ready low
    reset = 1'b1; #2; reset = 1'b0;
    step();
    start = 1'b1; if_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_valid", 32'(if_valid), 32'h1);
    check("bp_pc_held", 32'(if_pc), 32'h0);
    check("bp_instr_held", if_instr, 32'h11);
    check("bp_imem_pc", 32'(imem_pc), 32'h8);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    check("bp_resume_pc4", 32'(if_pc), 32'h4);
    check("bp_resume_imem", 32'(imem_pc), 32'hC);

    // Redirect flush with entries pc 4 and 8 buffered
    redirect_valid = 1'b1; redirect_pc = 8'h43;
    step();
    redirect_valid = 1'b0; if_ready = 1'b1;
    check("flush_empty", 32'(if_valid), 32'h0);
    check("flush_imem_pc", 32'(imem_pc), 32'h40);
    step();
    check("flush_tgt_valid", 32'(if_valid), 32'h1);
    check("flush_tgt_pc", 32'(if_pc), 32'h40);
    check("flush_tgt_instr", if_instr, 32'h11 * 17);

    // End of memory
    redirect_valid = 1'b1; redirect_pc = 8'd248;
    step();
    redirect_valid = 1'b0;
    check("eom_redirect_empty", 32'(if_valid), 32'h0);
    step();
    check("eom_pc248", 32'(if_pc), 32'd248);
    check("eom_instr248", if_instr, 32'h11 * 63);
    step();
    check("eom_pc252", 32'(if_pc), 32'd252);
    check("eom_instr252", if_instr, 32'h11 * 64);
    check("eom_not_busy", 32'(busy), 32'h0);
    check("eom_not_done_yet", 32'(done), 32'h0);
    step();
    check("eom_done", 32'(done), 32'h1);
    check("eom_drained", 32'(if_valid), 32'h0);
    check("eom_imem_hold", 32'(imem_pc), 32'd252);
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_ignores_start", 32'(done), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    step();
    redirect_valid = 1'b0;
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_imem_pc", 32'(imem_pc), 32'h0);

    // Stall drains the buffer without new pushes
    if_ready = 1'b0;
    step();
    step();
    stall = 1'b1; if_ready = 1'b1;
    step();
    check("stall_pop_pc4", 32'(if_pc), 32'h4);
    step();
    check("stall_drained", 32'(if_valid), 32'h0);
    step();
    check("stall_no_fetch", 32'(if_valid), 32'h0);
    check("stall_imem_hold", 32'(imem_pc), 32'h8);
    stall = 1'b0;
    step();
    check("unstall_pc8", 32'(if_pc), 32'h8);
    check("unstall_valid", 32'(if_valid), 32'h1);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 32'(if_valid), 32'h0);
    check("areset_busy", 32'(busy), 32'h0);
    check("areset_imem_pc", 32'(imem_pc), 32'h0);
    reset = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    step();
    redirect_valid = 1'b0;
    check("idle_ignores_redirect_pc", 32'(imem_pc), 32'h0);
    check("idle_ignores_redirect_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
